hazard_sched: RTL

Issue scheduler and hazard controller for the integer pipeline's writeback tag delay line. It tracks the destination register of every in-flight instruction in a DEPTH-stage shift chain of tags, and decides each cycle whether the decode-stage instruction may issue. It detects read-after-write hazards, drives operand forwarding selects, inserts bubbles on load-use stalls, and counts stall cycles for performance monitoring. It sits between decode and the EX/MEM/WB pipeline registers.

---
 rtl/hazard_sched.sv | 117 +++++++++++
 1 files changed

// File: rtl/hazard_sched.sv
// Issue scheduler: tracks in-flight destination tags in a DEPTH-stage shift chain and
// resolves RAW hazards into forwarding selects or decode stalls; stall/fwd/occupancy are combinational.
module hazard_sched #(
    parameter int DEPTH      = 3,
    parameter int LOAD_READY = 1,
    parameter int CNT_W      = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       issue_valid,
    input  logic                       issue_wen,
    input  logic                       issue_load,
    input  logic [4:0]                 issue_rd,
    input  logic [4:0]                 issue_rs1,
    input  logic [4:0]                 issue_rs2,
    input  logic                       issue_use1,
    input  logic                       issue_use2,
    input  logic                       flush,
    output logic                       stall,
    output logic                       fwd1_hit,
    output logic                       fwd2_hit,
    output logic [$clog2(DEPTH)-1:0]   fwd1_stage,
    output logic [$clog2(DEPTH)-1:0]   fwd2_stage,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [CNT_W-1:0]           stall_count
);

    localparam int SW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] tag_v;
    logic [DEPTH-1:0] tag_load;
    logic [4:0]       tag_rd [DEPTH];

    logic             not_ready1;
    logic             not_ready2;
    logic             accept;

    // Returns {hit, not_ready, stage}; only the youngest matching stage is considered.
    function automatic logic [SW+1:0] lookup(
        input logic             use_src,
        input logic [4:0]       rs,
        input logic [DEPTH-1:0] v,
        input logic [DEPTH-1:0] ld,
        input logic [DEPTH*5-1:0] rd_flat
    );
        logic          found;
        logic          hit;
        logic          nrdy;
        logic [SW-1:0] stg;
        found = 1'b0;
        hit   = 1'b0;
        nrdy  = 1'b0;
        stg   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!found && use_src && (rs != 5'd0) && v[k] && (rd_flat[k*5 +: 5] == rs)) begin
                found = 1'b1;
                if (!ld[k] || (k >= LOAD_READY)) begin
                    hit = 1'b1;
                    stg = SW'(k);
                end else begin
                    nrdy = 1'b1;
                end
            end
        end
        return {hit, nrdy, stg};
    endfunction

    logic [DEPTH*5-1:0] rd_flat;
    always_comb begin
        rd_flat = '0;
        for (int k = 0; k < DEPTH; k++) begin
            rd_flat[k*5 +: 5] = tag_rd[k];
        end
    end

    always_comb begin
        {fwd1_hit, not_ready1, fwd1_stage} = lookup(issue_use1, issue_rs1, tag_v, tag_load, rd_flat);
        {fwd2_hit, not_ready2, fwd2_stage} = lookup(issue_use2, issue_rs2, tag_v, tag_load, rd_flat);
        stall  = issue_valid & ~flush & (not_ready1 | not_ready2);
        accept = issue_valid & ~stall & ~flush;
    end

    always_comb begin
        occupancy = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occupancy = occupancy + OW'(tag_v[k]);
        end
    end

    // The chain advances unconditionally; a stalled or flushed slot becomes a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_v    <= '0;
            tag_load <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                tag_rd[k] <= 5'd0;
            end
        end else begin
            tag_v    <= {tag_v[DEPTH-2:0], accept & issue_wen & (issue_rd != 5'd0)};
            tag_load <= {tag_load[DEPTH-2:0], accept & issue_load};
            for (int k = DEPTH - 1; k > 0; k--) begin
                tag_rd[k] <= tag_rd[k-1];
            end
            tag_rd[0] <= accept ? issue_rd : 5'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
        end else if (stall && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule
